// File: rtl/poly_voice_engine.sv
// Polyphonic voice engine: sample tick generator, note-to-voice allocator with
// retrigger/oldest-voice stealing, and a time-multiplexed velocity-scaled mixer.
module poly_voice_engine_chk (
  input logic clk_i,
  input logic rst_i,
  input logic ce_i,
  input logic idle_i
);
  a_ce_in_idle: assert property (@(posedge clk_i) disable iff (rst_i) ce_i |-> idle_i);
endmodule

module poly_voice_engine #(
  parameter int VOICES    = 4,
  parameter int SAMPLE_W  = 12,
  parameter int DIVIDER   = 3125,
  parameter int MIX_SHIFT = 7
) (
  input  logic                         inClk,
  input  logic                         inReset,
  input  logic                         inNoteOn,
  input  logic                         inNoteOff,
  input  logic [6:0]                   inNote,
  input  logic [6:0]                   inVelocity,
  input  logic [VOICES*SAMPLE_W-1:0]   inVoiceSamples,
  output logic [VOICES-1:0]            outVoiceActive,
  output logic [VOICES*7-1:0]          outVoiceNote,
  output logic                         outSampleCE,
  output logic [SAMPLE_W-1:0]          outSample,
  output logic                         outSampleReady
);
  localparam int RW = $clog2(VOICES);
  localparam int CW = $clog2(DIVIDER);
  localparam int PW = SAMPLE_W + 8;
  localparam int AW = PW + RW;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUTPUT} state_t;

  logic [CW-1:0]        cnt_q;
  logic                 ce_q;
  logic [VOICES-1:0]    active_q, active_d;
  logic [6:0]           note_q [VOICES];
  logic [6:0]           note_d [VOICES];
  logic [6:0]           vel_q  [VOICES];
  logic [6:0]           vel_d  [VOICES];
  logic [RW-1:0]        rank_q [VOICES];
  logic [RW-1:0]        rank_d [VOICES];
  state_t               state_q;
  logic [RW-1:0]        idx_q;
  logic signed [AW-1:0] acc_q;
  logic [SAMPLE_W-1:0]  out_q;
  logic                 rdy_q;

  logic                 off_s, on_s, hit_s, free_s, sel_i_s, match_s;
  logic [RW-1:0]        hit_idx_s, free_idx_s, steal_idx_s, sel_s, old_rank_s;
  logic signed [SAMPLE_W-1:0] smp_s;
  logic [6:0]           vel_eff_s;
  logic signed [PW-1:0] a_s, b_s, prod_s;
  logic signed [AW-1:0] acc_nx_s;

  function automatic logic [SAMPLE_W-1:0] sat(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] sh;
    sh = a >>> MIX_SHIFT;
    if ((&sh[AW-1:SAMPLE_W-1]) || (~|sh[AW-1:SAMPLE_W-1])) return sh[SAMPLE_W-1:0];
    else if (sh[AW-1]) return {1'b1, {(SAMPLE_W-1){1'b0}}};
    else return {1'b0, {(SAMPLE_W-1){1'b1}}};
  endfunction

  always_ff @(posedge inClk or posedge inReset) begin
    if (inReset) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      ce_q  <= (cnt_q == CW'(DIVIDER-1));
      cnt_q <= (cnt_q == CW'(DIVIDER-1)) ? '0 : cnt_q + 1'b1;
    end
  end

  // Off is applied first; the on event then sees the post-off table.
  always_comb begin
    active_d = active_q;
    note_d = note_q;
    vel_d = vel_q;
    rank_d = rank_q;
    off_s = inNoteOff | (inNoteOn & (inVelocity == 7'd0));
    on_s = inNoteOn & (inVelocity != 7'd0);
    hit_s = 1'b0;
    free_s = 1'b0;
    hit_idx_s = '0;
    free_idx_s = '0;
    steal_idx_s = '0;
    match_s = 1'b0;
    sel_i_s = 1'b0;
    for (int i = 0; i < VOICES; i++)
      active_d[i] = active_q[i] & ~(off_s & (note_q[i] == inNote));
    for (int i = VOICES-1; i >= 0; i--) begin
      match_s = active_d[i] & (note_q[i] == inNote);
      hit_s = hit_s | match_s;
      hit_idx_s = match_s ? RW'(i) : hit_idx_s;
      free_s = free_s | ~active_d[i];
      free_idx_s = active_d[i] ? free_idx_s : RW'(i);
      steal_idx_s = (rank_q[i] == RW'(VOICES-1)) ? RW'(i) : steal_idx_s;
    end
    sel_s = hit_s ? hit_idx_s : (free_s ? free_idx_s : steal_idx_s);
    old_rank_s = rank_q[sel_s];
    for (int i = 0; i < VOICES; i++) begin
      sel_i_s = on_s & (RW'(i) == sel_s);
      active_d[i] = active_d[i] | sel_i_s;
      note_d[i] = sel_i_s ? inNote : note_q[i];
      vel_d[i] = sel_i_s ? inVelocity : vel_q[i];
      rank_d[i] = sel_i_s ? '0 :
                  ((on_s && (rank_q[i] < old_rank_s)) ? rank_q[i] + 1'b1 : rank_q[i]);
    end
  end

  always_ff @(posedge inClk or posedge inReset) begin
    if (inReset) begin
      active_q <= '0;
      for (int i = 0; i < VOICES; i++) begin
        note_q[i] <= 7'd0;
        vel_q[i]  <= 7'd0;
        rank_q[i] <= RW'(i);
      end
    end else begin
      active_q <= active_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      rank_q   <= rank_d;
    end
  end

  // Inactive voices contribute through a zero velocity rather than a mux on the product.
  always_comb begin
    smp_s = $signed(inVoiceSamples[idx_q*SAMPLE_W +: SAMPLE_W]);
    vel_eff_s = active_q[idx_q] ? vel_q[idx_q] : 7'd0;
    a_s = PW'(smp_s);
    b_s = $signed(PW'({1'b0, vel_eff_s}));
    prod_s = a_s * b_s;
    acc_nx_s = acc_q + AW'(prod_s);
  end

  always_ff @(posedge inClk or posedge inReset) begin
    if (inReset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rdy_q <= 1'b0;
          if (ce_q) begin
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc_q <= acc_nx_s;
          idx_q <= idx_q + 1'b1;
          if (idx_q == RW'(VOICES-1)) begin
            out_q   <= sat(acc_nx_s);
            rdy_q   <= 1'b1;
            state_q <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          rdy_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          rdy_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    outVoiceNote = '0;
    for (int i = 0; i < VOICES; i++) outVoiceNote[i*7 +: 7] = note_q[i];
  end

  assign outVoiceActive = active_q;
  assign outSampleCE    = ce_q;
  assign outSample      = out_q;
  assign outSampleReady = rdy_q;

  poly_voice_engine_chk u_chk (
    .clk_i  (inClk),
    .rst_i  (inReset),
    .ce_i   (ce_q),
    .idle_i (state_q == S_IDLE)
  );
endmodule
